// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, FSM states and default widths shared by the ALU issue controller
package alu_ctrl_pkg;
    localparam int DEF_DATA_W = 19;
    localparam int DEF_NREGS  = 8;
    localparam int DEF_AW     = 3;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_INC  = 5'd4;
    localparam logic [4:0] OP_DEC  = 5'd5;
    localparam logic [4:0] OP_AND1 = 5'd6;
    localparam logic [4:0] OP_OR1  = 5'd7;
    localparam logic [4:0] OP_XOR1 = 5'd8;
    localparam logic [4:0] OP_LAST = OP_XOR1;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_CAPT, S_WB_LO, S_WB_HI} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: register file with two operand read ports, a debug read port and one write port
module alu_regfile #(
    parameter int DATA_W = 19,
    parameter int NREGS  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    input  logic [AW-1:0]     rad,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rdd,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);
    logic [DATA_W-1:0] mem [NREGS];

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
    assign rdd = mem[rad];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file commands to an external ALU and writes results back
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int AW     = DEF_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [4:0]          cmd_opcode,
    input  logic [AW-1:0]       cmd_rs1,
    input  logic [AW-1:0]       cmd_rs2,
    input  logic [AW-1:0]       cmd_rd,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [4:0]          alu_opcode,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic                done,
    output logic                flag_zero,
    output logic                flag_dz,
    output logic                flag_ill,
    input  logic [AW-1:0]       dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);
    state_t              state_q, state_d;
    logic [AW-1:0]       rd_q, waddr;
    logic [2*DATA_W-1:0] res_q;
    logic [DATA_W-1:0]   rs1_data, rs2_data, wdata;
    logic                we, accept, legal, is_mul, dz_now, zero_now, done_set;

    assign accept   = cmd_valid && cmd_ready;
    assign legal    = cmd_opcode <= OP_LAST;
    assign is_mul   = alu_opcode == OP_MUL;
    assign dz_now   = alu_opcode == OP_DIV && alu_b == '0;
    assign zero_now = is_mul ? res_q == '0 : res_q[DATA_W-1:0] == '0;
    // done is registered, so it is raised one state ahead of the final writeback state
    assign done_set = (state_q == S_CAPT && !is_mul) || (state_q == S_WB_LO && is_mul);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept && legal ? S_EXEC : S_IDLE;
            S_EXEC:  state_d = S_CAPT;
            S_CAPT:  state_d = S_WB_LO;
            S_WB_LO: state_d = is_mul ? S_WB_HI : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // holding off ready during the done cycle keeps an illegal command's pulse isolated
    always_comb begin
        cmd_ready = state_q == S_IDLE && !done;
        we        = state_q == S_WB_LO || state_q == S_WB_HI;
        waddr     = state_q == S_WB_HI ? rd_q + AW'(1) : rd_q;
        wdata     = dz_now ? '0 : state_q == S_WB_HI ? res_q[2*DATA_W-1:DATA_W] : res_q[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rd_q       <= '0;
            res_q      <= '0;
            done       <= 1'b0;
            flag_zero  <= 1'b0;
            flag_dz    <= 1'b0;
            flag_ill   <= 1'b0;
        end else begin
            done <= done_set || (accept && !legal);
            if (accept) begin
                alu_a      <= rs1_data;
                alu_b      <= rs2_data;
                alu_opcode <= cmd_opcode;
                rd_q       <= cmd_rd;
            end
            if (state_q == S_EXEC) res_q <= alu_result;
            if (done_set) begin
                flag_zero <= zero_now;
                flag_dz   <= dz_now;
                flag_ill  <= 1'b0;
            end else if (accept && !legal) begin
                flag_zero <= 1'b0;
                flag_dz   <= 1'b0;
                flag_ill  <= 1'b1;
            end
        end
    end

    alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (cmd_rs1),
        .ra2   (cmd_rs2),
        .rad   (dbg_addr),
        .rd1   (rs1_data),
        .rd2   (rs2_data),
        .rdd   (dbg_data),
        .we    (we),
        .wa    (waddr),
        .wd    (wdata)
    );
endmodule
